// File: rtl/cntr8_seq_ctrl.sv
// 8-bit sequenced counter: load, count to a terminal value, then stop (one-shot)
// or reload and keep going (auto-reload). Pause holds the count without leaving the run.
module cntr8_seq_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       mode,
    input  logic [7:0] load_val,
    input  logic [7:0] term_val,
    output logic [7:0] count,
    output logic       busy,
    output logic       done,
    output logic [7:0] reload_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] reload_cnt_q, reload_cnt_d;

    // Event priority per edge: stop, start, terminal, pause, increment.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        reload_cnt_d = reload_cnt_q;

        if (stop) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else if (start) begin
            state_d = RUN;
            busy_d  = 1'b1;
            count_d = load_val;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (count_q == term_val) begin
                        done_d = 1'b1;
                        if (mode) begin
                            count_d = load_val;
                            if (reload_cnt_q != 8'hFF) begin
                                reload_cnt_d = reload_cnt_q + 8'd1;
                            end
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end else if (pause) begin
                        state_d = PAUSED;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end
                // Resuming costs one edge: the count only moves again from RUN.
                PAUSED: begin
                    if (!pause) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= 8'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            reload_cnt_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            reload_cnt_q <= reload_cnt_d;
        end
    end

    assign count      = count_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign reload_cnt = reload_cnt_q;

endmodule

// File: tb/tb_cntr8_seq_ctrl.sv
// Directed bench for cntr8_seq_ctrl: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_cntr8_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       pause;
    logic       mode;
    logic [7:0] load_val;
    logic [7:0] term_val;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic [7:0] reload_cnt;

    int vectors;
    int miscompares;

    cntr8_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .mode       (mode),
        .load_val   (load_val),
        .term_val   (term_val),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .reload_cnt (reload_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: bench did not finish within 200000 ns");
        $fatal(1, "[TB] timeout");
    end

    // Drive one edge's worth of inputs, then sample 1 ns after the rising edge.
    task automatic applyStimulus(input logic st, input logic sp, input logic ps,
                                 input logic md, input logic [7:0] lv, input logic [7:0] tv);
        start    = st;
        stop     = sp;
        pause    = ps;
        mode     = md;
        load_val = lv;
        term_val = tv;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] exp_count, input logic exp_busy,
                               input logic exp_done, input logic [7:0] exp_reload);
        vectors++;
        assert (count === exp_count) else begin
            miscompares++;
            $error("[TB] FAIL %s count: got %0d expected %0d", tag, count, exp_count);
        end
        vectors++;
        assert (busy === exp_busy) else begin
            miscompares++;
            $error("[TB] FAIL %s busy: got %b expected %b", tag, busy, exp_busy);
        end
        vectors++;
        assert (done === exp_done) else begin
            miscompares++;
            $error("[TB] FAIL %s done: got %b expected %b", tag, done, exp_done);
        end
        vectors++;
        assert (reload_cnt === exp_reload) else begin
            miscompares++;
            $error("[TB] FAIL %s reload_cnt: got %0d expected %0d", tag, reload_cnt, exp_reload);
        end
    endtask

    initial begin
        logic [7:0] exp_c;
        logic [7:0] exp_r;
        vectors     = 0;
        miscompares = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        pause    = 1'b0;
        mode     = 1'b0;
        load_val = 8'd0;
        term_val = 8'd0;

        // Reset state and quiet idle after release
        applyStimulus(0, 0, 0, 0, 8'd0, 8'd0);
        checkOutput("reset", 8'd0, 0, 0, 8'd0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 8'd9, 8'd9);
        checkOutput("idle_after_reset", 8'd0, 0, 0, 8'd0);

        // One-shot 3 -> 6
        applyStimulus(1, 0, 0, 0, 8'd3, 8'd6);
        checkOutput("oneshot_load", 8'd3, 1, 0, 8'd0);
        applyStimulus(0, 0, 0, 0, 8'd3, 8'd6);
        checkOutput("oneshot_4", 8'd4, 1, 0, 8'd0);
        applyStimulus(0, 0, 0, 0, 8'd3, 8'd6);
        checkOutput("oneshot_5", 8'd5, 1, 0, 8'd0);
        applyStimulus(0, 0, 0, 0, 8'd3, 8'd6);
        checkOutput("oneshot_6", 8'd6, 1, 0, 8'd0);
        applyStimulus(0, 0, 0, 0, 8'd3, 8'd6);
        checkOutput("oneshot_done", 8'd6, 0, 1, 8'd0);
        applyStimulus(0, 0, 0, 0, 8'd3, 8'd6);
        checkOutput("oneshot_hold", 8'd6, 0, 0, 8'd0);

        // Auto-reload 250 -> 2 with wrap through 255/0
        applyStimulus(1, 0, 0, 1, 8'd250, 8'd2);
        checkOutput("reload_load", 8'd250, 1, 0, 8'd0);
        exp_c = 8'd250;
        for (int i = 0; i < 8; i++) begin
            exp_c = exp_c + 8'd1;
            applyStimulus(0, 0, 0, 1, 8'd250, 8'd2);
            checkOutput("reload_run1", exp_c, 1, 0, 8'd0);
        end
        applyStimulus(0, 0, 0, 1, 8'd250, 8'd2);
        checkOutput("reload_term1", 8'd250, 1, 1, 8'd1);
        exp_c = 8'd250;
        for (int i = 0; i < 8; i++) begin
            exp_c = exp_c + 8'd1;
            applyStimulus(0, 0, 0, 1, 8'd250, 8'd2);
            checkOutput("reload_run2", exp_c, 1, 0, 8'd1);
        end
        applyStimulus(0, 0, 0, 1, 8'd250, 8'd2);
        checkOutput("reload_term2", 8'd250, 1, 1, 8'd2);
        applyStimulus(0, 1, 0, 1, 8'd250, 8'd2);
        checkOutput("reload_stop", 8'd250, 0, 0, 8'd2);

        // Pause held at 10
        applyStimulus(1, 0, 0, 0, 8'd8, 8'd200);
        checkOutput("pause_load", 8'd8, 1, 0, 8'd2);
        applyStimulus(0, 0, 0, 0, 8'd8, 8'd200);
        checkOutput("pause_9", 8'd9, 1, 0, 8'd2);
        applyStimulus(0, 0, 0, 0, 8'd8, 8'd200);
        checkOutput("pause_10", 8'd10, 1, 0, 8'd2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 0, 8'd8, 8'd200);
            checkOutput("pause_hold", 8'd10, 1, 0, 8'd2);
        end
        applyStimulus(0, 0, 0, 0, 8'd8, 8'd200);
        checkOutput("pause_resume", 8'd10, 1, 0, 8'd2);
        applyStimulus(0, 0, 0, 0, 8'd8, 8'd200);
        checkOutput("pause_11", 8'd11, 1, 0, 8'd2);
        applyStimulus(0, 0, 0, 0, 8'd8, 8'd200);
        checkOutput("pause_12", 8'd12, 1, 0, 8'd2);

        // Stop beats start
        applyStimulus(1, 1, 0, 0, 8'd99, 8'd200);
        checkOutput("stop_start", 8'd12, 0, 0, 8'd2);
        applyStimulus(0, 0, 0, 0, 8'd99, 8'd200);
        checkOutput("stop_idle", 8'd12, 0, 0, 8'd2);

        // Terminal beats pause
        applyStimulus(1, 0, 0, 0, 8'd20, 8'd21);
        checkOutput("tp_load", 8'd20, 1, 0, 8'd2);
        applyStimulus(0, 0, 0, 0, 8'd20, 8'd21);
        checkOutput("tp_21", 8'd21, 1, 0, 8'd2);
        applyStimulus(0, 0, 1, 0, 8'd20, 8'd21);
        checkOutput("tp_term", 8'd21, 0, 1, 8'd2);

        // load_val == term_val terminates on the first RUN edge
        applyStimulus(1, 0, 0, 0, 8'd40, 8'd40);
        checkOutput("eq_load", 8'd40, 1, 0, 8'd2);
        applyStimulus(0, 0, 0, 0, 8'd40, 8'd40);
        checkOutput("eq_term", 8'd40, 0, 1, 8'd2);

        // Asynchronous reset mid-run at 77
        applyStimulus(1, 0, 0, 0, 8'd70, 8'd100);
        checkOutput("ar_load", 8'd70, 1, 0, 8'd2);
        for (int i = 71; i <= 77; i++) begin
            applyStimulus(0, 0, 0, 0, 8'd70, 8'd100);
            checkOutput("ar_run", 8'(i), 1, 0, 8'd2);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_async", 8'd0, 0, 0, 8'd0);
        #2;
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 8'd70, 8'd100);
        checkOutput("ar_idle1", 8'd0, 0, 0, 8'd0);
        applyStimulus(0, 0, 0, 0, 8'd70, 8'd100);
        checkOutput("ar_idle2", 8'd0, 0, 0, 8'd0);

        // Restart while busy
        applyStimulus(1, 0, 0, 0, 8'd5, 8'd9);
        checkOutput("rs_load", 8'd5, 1, 0, 8'd0);
        applyStimulus(0, 0, 0, 0, 8'd5, 8'd9);
        checkOutput("rs_6", 8'd6, 1, 0, 8'd0);
        applyStimulus(1, 0, 0, 0, 8'd100, 8'd9);
        checkOutput("rs_restart", 8'd100, 1, 0, 8'd0);
        applyStimulus(0, 0, 0, 0, 8'd100, 8'd9);
        checkOutput("rs_101", 8'd101, 1, 0, 8'd0);

        // reload_cnt saturates at 255 (terminal on every edge)
        applyStimulus(1, 0, 0, 1, 8'd7, 8'd7);
        checkOutput("sat_load", 8'd7, 1, 0, 8'd0);
        for (int i = 1; i <= 260; i++) begin
            exp_r = (i > 255) ? 8'd255 : 8'(i);
            applyStimulus(0, 0, 0, 1, 8'd7, 8'd7);
            checkOutput("sat_reload", 8'd7, 1, 1, exp_r);
        end
        applyStimulus(0, 1, 0, 1, 8'd7, 8'd7);
        checkOutput("sat_stop", 8'd7, 0, 0, 8'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cntr8_seq_ctrl.md
CNTR8_SEQ_CTRL -- requirements
Module: cntr8_seq_ctrl

Interface
REQ-001 SHALL provide port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL provide port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL provide port start, input, 1 bit: load load_val into the counter and begin (or restart) a run.
REQ-004 SHALL provide port stop, input, 1 bit: abort the run and return to IDLE, count held.
REQ-005 SHALL provide port pause, input, 1 bit, level: while high in RUN, hold the count.
REQ-006 SHALL provide port mode, input, 1 bit: 0 = one-shot, 1 = auto-reload; sampled each cycle.
REQ-007 SHALL provide port load_val, input, 8 bits: start/reload value; sampled on the loading edge.
REQ-008 SHALL provide port term_val, input, 8 bits: terminal count; compared every RUN cycle.
REQ-009 SHALL provide port count, output, 8 bits, registered: current counter value.
REQ-010 SHALL provide port busy, output, 1 bit, registered: high in RUN or PAUSED.
REQ-011 SHALL provide port done, output, 1 bit, registered: one-cycle pulse per terminal event.
REQ-012 SHALL provide port reload_cnt, output, 8 bits, registered: number of auto-reload events, saturating at 255.

Function
REQ-013 SHALL implement exactly three states: IDLE, RUN and PAUSED.
REQ-014 SHALL evaluate events on each edge in this priority: stop > start > terminal > pause > increment.
REQ-015 SHALL, when stop=1 in any state, enter IDLE, hold count and deassert busy on the next edge, with done=0.
REQ-016 SHALL, when start=1 and stop=0 in any state, set count<=load_val and enter RUN (restart if already busy), with reload_cnt unchanged.
REQ-017 SHALL, in RUN when count==term_val (no stop/start) and mode=0, set done<=1, enter IDLE and hold count at term_val.
REQ-018 SHALL, in RUN when count==term_val (no stop/start) and mode=1, set done<=1, set count<=load_val, stay in RUN and increment reload_cnt (saturating at 255).
REQ-019 SHALL, in RUN with no higher-priority event and pause=1, enter PAUSED and hold count.
REQ-020 SHALL, in RUN with no event and pause=0, set count<=count+1 modulo 256 (255 -> 0 wraps and does not terminate).
REQ-021 SHALL, in PAUSED, hold count; pause=0 returns to RUN with no increment on that edge.
REQ-022 SHALL make done a single-cycle pulse, low on every edge without a terminal event.
REQ-023 SHALL, when load_val==term_val, detect the terminal on the first RUN edge after the loading edge.
REQ-024 SHALL keep the IDLE count static, with no increment and no terminal detection in IDLE or PAUSED.
REQ-025 SHALL set latency start-edge -> first increment to 1 cycle, and terminal-edge -> done high to 0 cycles (done registered on the same edge).

Reset
REQ-026 SHALL, while rst_n=0, immediately force state=IDLE, count=0, busy=0, done=0 and reload_cnt=0, independent of clk.
REQ-027 SHALL, on rst_n assertion mid-run, discard the run; after release, the block idles until the next start.

Verification
REQ-028 SHALL cover: reset, then start with load_val=3, term_val=6, mode=0 -> count 3,4,5,6; done pulses once at the edge leaving count=6; busy falls with it; count holds at 6.
REQ-029 SHALL cover: mode=1, load_val=250, term_val=2 -> count 250..255,0,1,2,250; done pulses at each return to 250; reload_cnt increments once per terminal event.
REQ-030 SHALL cover: pause held 4 cycles at count=10 -> count holds at 10, busy=1; after release, count=11 one edge later than it would reach 11 unpaused.
REQ-031 SHALL cover: stop and start both high in RUN -> IDLE, count held, done=0.
REQ-032 SHALL cover: count==term_val and pause=1 in the same cycle -> terminal wins: done=1 and IDLE (mode=0).
REQ-033 SHALL cover: rst_n low asynchronously mid-run at count=77 -> outputs zero before the next clk edge; no activity until start.
